// File: rtl/serial_adder_ctrl_pkg.sv
// Shared encodings for the serial add/sub controller: FSM states and op select.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// Single-bit full adder cell, time-shared by the serial add/sub controller.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full adder cell evaluated LSB first, once per clock,
// with operands latched on start and result/carry/overflow returned with a done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_sh, b_sh, res;
  logic [CNT_W-1:0]   cnt;
  logic               carry, carry_msb_in;
  logic               fa_s, fa_co;
  logic               last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  fulladder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_s),
    .c_out (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (last_bit) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Subtraction is a + ~b + 1: invert B at load and seed the carry with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh         <= '0;
      b_sh         <= '0;
      res          <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      carry_msb_in <= 1'b0;
      sum          <= '0;
      c_out        <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= (sub == OP_SUB) ? ~b : b;
            carry <= (sub != OP_ADD);
            cnt   <= '0;
            res   <= '0;
          end
        end
        ST_RUN: begin
          res   <= {fa_s, res[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 2)) carry_msb_in <= fa_co;
          if (last_bit) begin
            sum      <= {fa_s, res[WIDTH-1:1]};
            c_out    <= fa_co;
            overflow <= fa_co ^ carry_msb_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
